bikelight_led_driver: RTL and testbench

//  Consumer of the bikelight mode bus: converts the 4-bit mode from the bikelight controller into the physical LED waveform.
//  - Generates steady, blink, dimmed (PWM) and strobe patterns from a clock prescaler.
//  - Restarts the pattern cleanly whenever the mode changes.
//  - Sits between the bikelight controller and the LED pin.

---
 rtl/bikelight_pkg.sv | 20 ++
 rtl/bikelight_led_driver_if.sv | 13 +
 rtl/bikelight_prescaler.sv | 28 ++
 rtl/bikelight_led_driver.sv | 123 ++++++++++++
 tb/tb_bikelight_led_driver.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/bikelight_pkg.sv
// Mode encoding shared by the bikelight controller and the LED driver.
package bikelight_pkg;

    localparam int unsigned MODE_W = 4;

    localparam logic [MODE_W-1:0] MODE_OFF    = 4'd0;
    localparam logic [MODE_W-1:0] MODE_ON     = 4'd1;
    localparam logic [MODE_W-1:0] MODE_BLINK  = 4'd2;
    localparam logic [MODE_W-1:0] MODE_DIM    = 4'd3;
    localparam logic [MODE_W-1:0] MODE_STROBE = 4'd4;

    function automatic logic mode_is_legal(input logic [MODE_W-1:0] m);
        return m <= MODE_STROBE;
    endfunction

    function automatic logic mode_is_lit(input logic [MODE_W-1:0] m);
        return (m != MODE_OFF) && (m <= MODE_STROBE);
    endfunction

endpackage

// File: rtl/bikelight_led_driver_if.sv
// Mode bus between the bikelight controller (master) and the LED driver (slave).
interface bikelight_led_driver_if;
    import bikelight_pkg::*;

    logic [MODE_W-1:0] mode;
    logic              led;
    logic              sync;
    logic              mode_err;

    modport master (output mode, input led, input sync, input mode_err);
    modport slave  (input mode, output led, output sync, output mode_err);

endinterface

// File: rtl/bikelight_prescaler.sv
// Pattern tick prescaler: counts 0..TICK_DIV-1, tick on the terminal count.
module bikelight_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (cnt_q == CntMax) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/bikelight_led_driver.sv
// Turns the bikelight mode into the LED waveform (steady, blink, PWM dim, strobe).
// Optional soft-start fade on OFF->lit is enabled by defining BIKELIGHT_FADE_EN.
module bikelight_led_driver
    import bikelight_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 4,
    parameter int unsigned PWM_BITS      = 4,
    parameter int unsigned DIM_DUTY      = 4,
    parameter int unsigned BLINK_TICKS   = 8,
    parameter int unsigned STROBE_ON     = 1,
    parameter int unsigned STROBE_PERIOD = 8
) (
    input logic                  clk,
    input logic                  rst,
    bikelight_led_driver_if.slave bus
);

    localparam int unsigned BlinkLen = 2 * BLINK_TICKS;
    localparam int unsigned PhaseCnt = (BlinkLen > STROBE_PERIOD) ? BlinkLen : STROBE_PERIOD;
    localparam int unsigned PhaseW   = (PhaseCnt > 1) ? $clog2(PhaseCnt) : 1;
    localparam logic [PhaseW-1:0] BlinkLast  = PhaseW'(BlinkLen - 1);
    localparam logic [PhaseW-1:0] StrobeLast = PhaseW'(STROBE_PERIOD - 1);

    logic [MODE_W-1:0]   mode_q;
    logic [PhaseW-1:0]   phase_q, phase_d, phase_last;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                led_q, led_d, led_pat;
    logic                sync_q, sync_d;
    logic                err_q;
    logic                chg, tick, wrap, periodic;

    assign chg = (bus.mode != mode_q);

    bikelight_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (chg),
        .tick(tick)
    );

    always_comb begin
        periodic   = (bus.mode == MODE_BLINK) || (bus.mode == MODE_STROBE);
        phase_last = (bus.mode == MODE_BLINK) ? BlinkLast : StrobeLast;
        pwm_d      = chg ? '0 : pwm_q + PWM_BITS'(1);
        phase_d    = '0;
        wrap       = 1'b0;
        // A mode change restarts the pattern even if a tick lands on the same edge.
        if (!chg && periodic) begin
            if (!tick) begin
                phase_d = phase_q;
            end else if (phase_q == phase_last) begin
                wrap = 1'b1;
            end else begin
                phase_d = phase_q + PhaseW'(1);
            end
        end

        case (bus.mode)
            MODE_OFF:    led_pat = 1'b0;
            MODE_ON:     led_pat = 1'b1;
            MODE_BLINK:  led_pat = 32'(phase_d) < BLINK_TICKS;
            MODE_DIM:    led_pat = 32'(pwm_d) < DIM_DUTY;
            MODE_STROBE: led_pat = 32'(phase_d) < STROBE_ON;
            default:     led_pat = 1'b0;
        endcase

        sync_d = periodic && (chg || wrap);
    end

`ifdef BIKELIGHT_FADE_EN
    logic [PWM_BITS-1:0] fade_q, fade_d;

    // Lit->lit changes keep the current fade level; only leaving OFF restarts it.
    always_comb begin
        fade_d = fade_q;
        if (!mode_is_lit(bus.mode)) begin
            fade_d = '0;
        end else if (chg) begin
            if (mode_q == MODE_OFF) begin
                fade_d = '0;
            end
        end else if (tick && (fade_q != '1)) begin
            fade_d = fade_q + PWM_BITS'(1);
        end
        led_d = led_pat && ((fade_d == '1) || (pwm_d < fade_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fade_q <= '0;
        end else begin
            fade_q <= fade_d;
        end
    end
`else
    assign led_d = led_pat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_OFF;
            phase_q <= '0;
            pwm_q   <= '0;
            led_q   <= 1'b0;
            sync_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            mode_q  <= bus.mode;
            phase_q <= phase_d;
            pwm_q   <= pwm_d;
            led_q   <= led_d;
            sync_q  <= sync_d;
            err_q   <= !mode_is_legal(bus.mode);
        end
    end

    assign bus.led      = led_q;
    assign bus.sync     = sync_q;
    assign bus.mode_err = err_q;

endmodule

// File: tb/tb_bikelight_led_driver.sv
// Bench for bikelight_led_driver: directed and random mode sequences against a cycle-count model.
module tb_bikelight_led_driver;
    import bikelight_pkg::*;

    localparam int unsigned TD  = 4;
    localparam int unsigned PB  = 4;
    localparam int unsigned DD  = 4;
    localparam int unsigned BT  = 8;
    localparam int unsigned SON = 1;
    localparam int unsigned SP  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bikelight_led_driver_if bus();

    bikelight_led_driver #(
        .TICK_DIV     (TD),
        .PWM_BITS     (PB),
        .DIM_DUTY     (DD),
        .BLINK_TICKS  (BT),
        .STROBE_ON    (SON),
        .STROBE_PERIOD(SP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int hi_cnt   = 0;
    int sync_cnt = 0;

    // Model: everything derives from k = cycles since the pattern last restarted.
    int   k      = 0;
    int   fade   = 0;
    logic [MODE_W-1:0] m_prev = MODE_OFF;
    logic exp_led  = 1'b0;
    logic exp_sync = 1'b0;
    logic exp_err  = 1'b0;

    task automatic model_update();
        logic [MODE_W-1:0] m;
        logic chg;
        int pwm_period;
        m = bus.mode;
        pwm_period = 1 << PB;
        if (rst) begin
            k = 0; fade = 0; m_prev = MODE_OFF;
            exp_led = 1'b0; exp_sync = 1'b0; exp_err = 1'b0;
            return;
        end
        chg = (m != m_prev);
        k = chg ? 0 : k + 1;
        case (m)
            MODE_ON:     exp_led = 1'b1;
            MODE_BLINK:  exp_led = ((k / TD) % (2 * BT)) < BT;
            MODE_DIM:    exp_led = (k % pwm_period) < DD;
            MODE_STROBE: exp_led = ((k / TD) % SP) < SON;
            default:     exp_led = 1'b0;
        endcase
        exp_sync = ((m == MODE_BLINK) && (k % (2 * BT * TD) == 0)) ||
                   ((m == MODE_STROBE) && (k % (SP * TD) == 0));
        exp_err = (m > MODE_STROBE);
`ifdef BIKELIGHT_FADE_EN
        if (m == MODE_OFF || m > MODE_STROBE) fade = 0;
        else if (chg) begin
            if (m_prev == MODE_OFF) fade = 0;
        end else if (k % TD == 0 && fade < pwm_period - 1) fade++;
        if (fade != pwm_period - 1 && (k % pwm_period) >= fade) exp_led = 1'b0;
`endif
        m_prev = m;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (k=%0d t=%0t)", tag, obs, exp, k, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_bit("led", bus.led, exp_led);
        check_bit("sync", bus.sync, exp_sync);
        check_bit("mode_err", bus.mode_err, exp_err);
        if (bus.led === 1'b1) hi_cnt++;
        if (bus.sync === 1'b1) sync_cnt++;
    endtask

    task automatic run(input logic [MODE_W-1:0] m, input int n);
        bus.mode = m;
        hi_cnt = 0;
        sync_cnt = 0;
        repeat (n) step();
    endtask

    initial begin
        logic [MODE_W-1:0] rm;
        int len;
        bus.mode = MODE_ON;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
`ifndef BIKELIGHT_FADE_EN
        check_bit("reset_release_led", bus.led, 1'b1);
`endif
        run(MODE_OFF, 5);

        run(MODE_BLINK, 128);
`ifndef BIKELIGHT_FADE_EN
        check_int("blink_high_cycles", hi_cnt, 64);
`endif
        check_int("blink_sync_count", sync_cnt, 2);

        run(MODE_OFF, 3);
        run(MODE_DIM, 64);
`ifndef BIKELIGHT_FADE_EN
        check_int("dim_high_cycles", hi_cnt, 16);
`endif
        check_int("dim_sync_count", sync_cnt, 0);

        run(MODE_STROBE, 64);
`ifndef BIKELIGHT_FADE_EN
        check_int("strobe_high_cycles", hi_cnt, 8);
`endif
        check_int("strobe_sync_count", sync_cnt, 2);

        run(MODE_OFF, 3);
        run(MODE_BLINK, 40);
        bus.mode = MODE_STROBE;
        step();
`ifndef BIKELIGHT_FADE_EN
        check_bit("midchange_led", bus.led, 1'b1);
`endif
        check_bit("midchange_sync", bus.sync, 1'b1);
        run(MODE_STROBE, 20);

        bus.mode = 4'd9;
        step();
        check_bit("illegal_led", bus.led, 1'b0);
        check_bit("illegal_err", bus.mode_err, 1'b1);
        run(4'd9, 5);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) step();
                rst = 1'b0;
            end
            if ($urandom_range(0, 11) < 10) rm = 4'($urandom_range(0, 4));
            else rm = 4'($urandom_range(5, 15));
            len = $urandom_range(1, 90);
            run(rm, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
